// File: rtl/riscv_uart_pkg.sv
// Shared definitions for riscv_uart: register offsets, STATUS bit positions,
// TX/RX state encodings and the baud divisor floor.
package riscv_uart_pkg;

    typedef enum logic [11:0] {
        REG_STATUS = 12'h000,
        REG_TXDATA = 12'h004,
        REG_RXDATA = 12'h008,
        REG_DIV    = 12'h00C
    } reg_off_e;

    localparam int ST_TX_NOT_FULL  = 0;
    localparam int ST_RX_NOT_EMPTY = 1;
    localparam int ST_RX_OVERRUN   = 2;
    localparam int ST_RX_FRAME_ERR = 3;
    localparam int ST_TX_BUSY      = 4;

    localparam logic [15:0] DIV_MIN = 16'd4;

    typedef logic [1:0] tx_state_t;
    localparam tx_state_t TX_IDLE  = 2'd0;
    localparam tx_state_t TX_START = 2'd1;
    localparam tx_state_t TX_DATA  = 2'd2;
    localparam tx_state_t TX_STOP  = 2'd3;

    typedef logic [1:0] rx_state_t;
    localparam rx_state_t RX_IDLE  = 2'd0;
    localparam rx_state_t RX_START = 2'd1;
    localparam rx_state_t RX_DATA  = 2'd2;
    localparam rx_state_t RX_STOP  = 2'd3;

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/riscv_uart_fifo.sv
// Synchronous FIFO with count-based full/empty; head data is always visible.
module riscv_uart_fifo
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
)
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/riscv_uart.sv
// APB-style UART with TX/RX FIFOs and a programmable bit divisor.
// Receiver present only when RISCV_UART_RX_EN is defined.
//   state    | meaning
//   TX_IDLE  | line high, waiting for TX FIFO data
//   TX_START | driving start bit
//   TX_DATA  | shifting 8 data bits LSB first
//   TX_STOP  | driving stop bit; reloads directly if FIFO has more data
//   RX_IDLE  | waiting for synced falling edge
//   RX_START | waiting to mid start bit, rejects glitches
//   RX_DATA  | sampling data bits at bit centre
//   RX_STOP  | sampling stop bit, push or flag error
module riscv_uart
    import riscv_uart_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_RESET  = 868
)
(
    input  logic            clk,
    input  logic            rstn,
    input  logic            sel,
    input  logic            enable,
    input  logic            write,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            txd,
    input  logic            rxd
);
    logic [11:0] reg_addr;
    logic        acc_wr;
    logic        acc_rd;
    logic [15:0] div_q;
    logic        unused_bits;

    assign reg_addr    = addr[11:0];
    assign acc_wr      = sel && enable && write;
    assign acc_rd      = sel && enable && !write;
    assign unused_bits = ^{addr[XLEN-1:12], wdata[XLEN-1:16]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            div_q <= 16'(DIV_RESET);
        else if (acc_wr && reg_addr == REG_DIV)
            div_q <= clamp_div(wdata[15:0]);
    end

    // ---------------- transmitter ----------------
    logic       txf_full, txf_empty, tx_load;
    logic [7:0] txf_rdata;
    tx_state_t  tx_state;
    logic [15:0] tx_div, tx_cnt;
    logic [2:0] tx_bit;
    logic [7:0] tx_shift;
    logic       txd_q;
    logic       tx_busy;

    riscv_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (acc_wr && reg_addr == REG_TXDATA),
        .pop   (tx_load),
        .wdata (wdata[7:0]),
        .rdata (txf_rdata),
        .full  (txf_full),
        .empty (txf_empty)
    );

    assign tx_load = !txf_empty &&
                     ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_cnt == '0));
    assign tx_busy = (tx_state != TX_IDLE) || !txf_empty;
    assign txd     = txd_q;

    // txd is registered from the state, so the line lags the FSM by one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state <= TX_IDLE;
            tx_div   <= '0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            txd_q    <= 1'b1;
        end else begin
            txd_q <= (tx_state == TX_START) ? 1'b0 :
                     (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;
            if (tx_load) begin
                tx_state <= TX_START;
                tx_shift <= txf_rdata;
                tx_div   <= div_q;
                tx_cnt   <= div_q - 16'd1;
            end else begin
                case (tx_state)
                    TX_START: begin
                        if (tx_cnt == '0) begin
                            tx_state <= TX_DATA;
                            tx_cnt   <= tx_div - 16'd1;
                            tx_bit   <= 3'd7;
                        end else begin
                            tx_cnt <= tx_cnt - 16'd1;
                        end
                    end
                    TX_DATA: begin
                        if (tx_cnt == '0) begin
                            tx_shift <= tx_shift >> 1;
                            tx_cnt   <= tx_div - 16'd1;
                            if (tx_bit == '0) tx_state <= TX_STOP;
                            else              tx_bit   <= tx_bit - 3'd1;
                        end else begin
                            tx_cnt <= tx_cnt - 16'd1;
                        end
                    end
                    TX_STOP: begin
                        if (tx_cnt == '0) tx_state <= TX_IDLE;
                        else              tx_cnt   <= tx_cnt - 16'd1;
                    end
                    default: tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    // ---------------- receiver ----------------
    logic       rx_not_empty;
    logic       rx_overrun;
    logic       rx_frame_err;
    logic [7:0] rx_head;

`ifdef RISCV_UART_RX_EN
    logic        rx_s1, rx_s2, rx_prev;
    rx_state_t   rx_state;
    logic [15:0] rx_div, rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_stop_now, rx_push, ovr_set, ferr_set;
    logic        rxf_full, rxf_empty;
    logic [7:0]  rxf_rdata;

    assign rx_stop_now  = (rx_state == RX_STOP) && (rx_cnt == '0);
    assign rx_push      = rx_stop_now && rx_s2 && !rxf_full;
    assign ovr_set      = rx_stop_now && rx_s2 && rxf_full;
    assign ferr_set     = rx_stop_now && !rx_s2;
    assign rx_not_empty = !rxf_empty;
    assign rx_head      = rxf_empty ? 8'h00 : rxf_rdata;

    riscv_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (rx_push),
        .pop   (acc_rd && reg_addr == REG_RXDATA),
        .wdata (rx_shift),
        .rdata (rxf_rdata),
        .full  (rxf_full),
        .empty (rxf_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_state <= RX_IDLE;
            rx_div   <= '0;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= RX_START;
                        rx_div   <= div_q;
                        rx_cnt   <= (div_q >> 1) - 16'd1;
                    end
                end
                RX_START: begin
                    if (rx_cnt == '0) begin
                        if (rx_s2) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_DATA;
                            rx_cnt   <= rx_div - 16'd1;
                            rx_bit   <= 3'd7;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_cnt   <= rx_div - 16'd1;
                        if (rx_bit == '0) rx_state <= RX_STOP;
                        else              rx_bit   <= rx_bit - 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: begin
                    if (rx_cnt == '0) rx_state <= RX_IDLE;
                    else              rx_cnt   <= rx_cnt - 16'd1;
                end
            endcase
        end
    end

    // A new event in the same cycle as a W1C keeps the bit set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (ovr_set)
                rx_overrun <= 1'b1;
            else if (acc_wr && reg_addr == REG_STATUS && wdata[ST_RX_OVERRUN])
                rx_overrun <= 1'b0;
            if (ferr_set)
                rx_frame_err <= 1'b1;
            else if (acc_wr && reg_addr == REG_STATUS && wdata[ST_RX_FRAME_ERR])
                rx_frame_err <= 1'b0;
        end
    end
`else
    logic unused_rxd;
    assign unused_rxd   = rxd;
    assign rx_not_empty = 1'b0;
    assign rx_overrun   = 1'b0;
    assign rx_frame_err = 1'b0;
    assign rx_head      = 8'h00;
`endif

    always_comb begin
        rdata = '0;
        case (reg_addr)
            REG_STATUS: begin
                rdata[ST_TX_NOT_FULL]  = !txf_full;
                rdata[ST_RX_NOT_EMPTY] = rx_not_empty;
                rdata[ST_RX_OVERRUN]   = rx_overrun;
                rdata[ST_RX_FRAME_ERR] = rx_frame_err;
                rdata[ST_TX_BUSY]      = tx_busy;
            end
            REG_RXDATA: rdata[7:0]  = rx_head;
            REG_DIV:    rdata[15:0] = div_q;
            default:    rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_riscv_uart.sv
// Self-checking bench for riscv_uart: serial frames are predicted from the
// frame format and compared bit by bit; RX tests depend on RISCV_UART_RX_EN.
module tb_riscv_uart;
    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        sel = 1'b0, enable = 1'b0, write = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        txd;
    logic        rxd = 1'b1;

    int checks = 0;
    int failures = 0;

    logic exp_bits[$];
    int   exp_durs[$];

    riscv_uart #(.XLEN(32), .FIFO_DEPTH(8), .DIV_RESET(868)) dut (
        .clk(clk), .rstn(rstn), .sel(sel), .enable(enable), .write(write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .txd(txd), .rxd(rxd)
    );

    always #5 clk = ~clk;

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        sel = 1'b1; enable = 1'b1; write = 1'b1; addr = {20'h0, a}; wdata = d;
        @(posedge clk);
        #1;
        sel = 1'b0; enable = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
        sel = 1'b1; enable = 1'b1; write = 1'b0; addr = {20'h0, a};
        @(negedge clk);
        d = rdata;
        @(posedge clk);
        #1;
        sel = 1'b0; enable = 1'b0;
    endtask

    // Frame = start 0, data LSB first, stop 1, each bit lasting div cycles.
    task automatic add_frame(input logic [7:0] b, input int div);
        exp_bits.push_back(1'b0); exp_durs.push_back(div);
        for (int i = 0; i < 8; i++) begin
            exp_bits.push_back(b[i]); exp_durs.push_back(div);
        end
        exp_bits.push_back(1'b1); exp_durs.push_back(div);
    endtask

    // Started in the same slot as the write whose edge accepts the first byte.
    task automatic check_tx_stream(input string name, input bit chk_busy);
        @(posedge clk); #1;
        checks++;
        if (txd !== 1'b1) begin
            failures++; $display("FAIL %s_idle_e0 txd=%b expected=1", name, txd);
        end
        @(posedge clk); #1;
        checks++;
        if (txd !== 1'b1) begin
            failures++; $display("FAIL %s_idle_e1 txd=%b expected=1", name, txd);
        end
        for (int i = 0; i < exp_bits.size(); i++) begin
            for (int k = 0; k < exp_durs[i]; k++) begin
                @(posedge clk); #1;
                if (k == 0 || k == exp_durs[i] - 1) begin
                    checks++;
                    if (txd !== exp_bits[i]) begin
                        failures++;
                        $display("FAIL %s_bit%0d_cyc%0d txd=%b expected=%b", name, i, k, txd, exp_bits[i]);
                    end
                end
                if (chk_busy && k == 0 && i < exp_bits.size() - 1) begin
                    checks++;
                    if (rdata[4] !== 1'b1) begin
                        failures++; $display("FAIL %s_busy_bit%0d got=%b expected=1", name, i, rdata[4]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        #1 rstn = 1'b0;
        #1;
        checks++;
        if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd got=%b expected=1", txd); end
        bus_read(12'h000, r);
        checks++;
        if (r !== 32'h1) begin failures++; $display("FAIL reset_status got=%h expected=%h", r, 32'h1); end
        bus_read(12'h00C, r);
        checks++;
        if (r !== 32'd868) begin failures++; $display("FAIL reset_div got=%0d expected=868", r); end
        bus_read(12'h008, r);
        checks++;
        if (r !== 32'h0) begin failures++; $display("FAIL reset_rxdata got=%h expected=0", r); end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_div();
        logic [31:0] d, r;
        logic [15:0] e;
        for (int i = 0; i < 6; i++) begin
            d = (i < 3) ? 32'($urandom_range(0, 5)) : $urandom;
            e = (d[15:0] < 16'd4) ? 16'd4 : d[15:0];
            bus_write(12'h00C, d);
            bus_read(12'h00C, r);
            checks++;
            if (r !== {16'h0, e}) begin
                failures++; $display("FAIL div_write_%0d wrote=%h got=%h expected=%h", i, d, r, {16'h0, e});
            end
        end
        bus_read(12'h010, r);
        checks++;
        if (r !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h expected=0", r); end
    endtask

    task automatic test_tx_basic();
        logic [31:0] r;
        bus_write(12'h00C, 32'd4);
        exp_bits.delete(); exp_durs.delete();
        add_frame(8'hA5, 4);
        fork
            begin
                bus_write(12'h004, 32'hA5);
                sel = 1'b1; enable = 1'b1; write = 1'b0; addr = 32'h0;
            end
            check_tx_stream("tx_a5", 1'b1);
        join
        sel = 1'b0; enable = 1'b0;
        bus_read(12'h000, r);
        checks++;
        if (r !== 32'h1) begin failures++; $display("FAIL tx_a5_status_end got=%h expected=1", r); end
    endtask

    task automatic test_tx_random();
        logic [31:0] r;
        int n, div0, div1;
        logic [7:0] bytes [8];
        for (int it = 0; it < 2; it++) begin
            n    = $urandom_range(2, 8);
            div0 = $urandom_range(4, 8);
            div1 = $urandom_range(4, 8);
            for (int i = 0; i < 8; i++) bytes[i] = 8'($urandom);
            bus_write(12'h00C, 32'(div0));
            exp_bits.delete(); exp_durs.delete();
            // DIV changes during the first frame, so only later frames use div1.
            for (int i = 0; i < n; i++) add_frame(bytes[i], (i == 0) ? div0 : div1);
            fork
                begin
                    for (int i = 0; i < n; i++) bus_write(12'h004, {24'h0, bytes[i]});
                    bus_write(12'h00C, 32'(div1));
                end
                check_tx_stream($sformatf("tx_rand%0d", it), 1'b0);
            join
            bus_read(12'h000, r);
            checks++;
            if ((r & 32'h11) !== 32'h1) begin
                failures++; $display("FAIL tx_rand%0d_status_end got=%h expected_masked=1", it, r);
            end
        end
    endtask

    // First byte leaves the FIFO one cycle after its write, so DEPTH+1 bytes fit.
    task automatic test_fifo_full();
        logic [31:0] r;
        bus_write(12'h00C, 32'd4);
        exp_bits.delete(); exp_durs.delete();
        for (int i = 0; i < 9; i++) add_frame(8'(i), 4);
        fork
            begin
                for (int i = 0; i < 10; i++) bus_write(12'h004, 32'(i));
                bus_read(12'h000, r);
                checks++;
                if (r[0] !== 1'b0 || r[4] !== 1'b1) begin
                    failures++; $display("FAIL fifo_full_status got=%h expected_bits0,4=0,1", r);
                end
            end
            check_tx_stream("fifo_full", 1'b0);
        join
        wait_cycles(8);
        checks++;
        if (txd !== 1'b1) begin failures++; $display("FAIL fifo_full_dropped txd=%b expected=1", txd); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] r;
        bus_write(12'h00C, 32'd8);
        bus_write(12'h004, 32'h00);
        wait_cycles(4);
        checks++;
        if (txd !== 1'b0) begin failures++; $display("FAIL rstmid_pre txd=%b expected=0", txd); end
        rstn = 1'b0;
        #1;
        checks++;
        if (txd !== 1'b1) begin failures++; $display("FAIL rstmid_txd got=%b expected=1", txd); end
        bus_read(12'h00C, r);
        checks++;
        if (r !== 32'd868) begin failures++; $display("FAIL rstmid_div got=%0d expected=868", r); end
        bus_read(12'h000, r);
        checks++;
        if (r !== 32'h1) begin failures++; $display("FAIL rstmid_status got=%h expected=1", r); end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        wait_cycles(20);
        checks++;
        if (txd !== 1'b1) begin failures++; $display("FAIL rstmid_abandon txd=%b expected=1", txd); end
        bus_read(12'h000, r);
        checks++;
        if (r !== 32'h1) begin failures++; $display("FAIL rstmid_status_after got=%h expected=1", r); end
    endtask

    task automatic send_rx(input logic [7:0] b, input int div, input logic stop);
        rxd = 1'b0;
        wait_cycles(div);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_cycles(div);
        end
        rxd = stop;
        wait_cycles(div);
        rxd = 1'b1;
    endtask

`ifdef RISCV_UART_RX_EN
    task automatic test_rx_basic();
        logic [31:0] r;
        bus_write(12'h00C, 32'd16);
        send_rx(8'h3C, 16, 1'b1);
        bus_read(12'h000, r);
        checks++;
        if (r !== 32'h3) begin failures++; $display("FAIL rx_basic_status got=%h expected=3", r); end
        bus_read(12'h008, r);
        checks++;
        if (r !== 32'h3C) begin failures++; $display("FAIL rx_basic_data got=%h expected=3c", r); end
        bus_read(12'h000, r);
        checks++;
        if (r !== 32'h1) begin failures++; $display("FAIL rx_basic_status_after got=%h expected=1", r); end
    endtask

    task automatic test_rx_random();
        logic [31:0] r;
        logic [7:0]  q[$];
        logic [7:0]  b;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            send_rx(b, 16, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(12'h008, r);
            checks++;
            if (r !== {24'h0, q[i]}) begin
                failures++; $display("FAIL rx_rand_%0d got=%h expected=%h", i, r, q[i]);
            end
        end
        bus_read(12'h008, r);
        checks++;
        if (r !== 32'h0) begin failures++; $display("FAIL rx_empty_read got=%h expected=0", r); end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] r;
        logic [7:0]  q[$];
        logic [7:0]  b;
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            send_rx(b, 16, 1'b1);
        end
        bus_read(12'h000, r);
        checks++;
        if (r !== 32'h7) begin failures++; $display("FAIL rx_ovr_status got=%h expected=7", r); end
        bus_write(12'h000, 32'h4);
        bus_read(12'h000, r);
        checks++;
        if (r !== 32'h3) begin failures++; $display("FAIL rx_ovr_w1c got=%h expected=3", r); end
        for (int i = 0; i < 8; i++) begin
            bus_read(12'h008, r);
            checks++;
            if (r !== {24'h0, q[i]}) begin
                failures++; $display("FAIL rx_ovr_data_%0d got=%h expected=%h", i, r, q[i]);
            end
        end
        bus_read(12'h000, r);
        checks++;
        if (r !== 32'h1) begin failures++; $display("FAIL rx_ovr_drained got=%h expected=1", r); end
    endtask

    task automatic test_rx_frame_err();
        logic [31:0] r;
        send_rx(8'h55, 16, 1'b0);
        bus_read(12'h000, r);
        checks++;
        if (r !== 32'h9) begin failures++; $display("FAIL rx_ferr_status got=%h expected=9", r); end
        bus_write(12'h000, 32'h8);
        bus_read(12'h000, r);
        checks++;
        if (r !== 32'h1) begin failures++; $display("FAIL rx_ferr_w1c got=%h expected=1", r); end
        rxd = 1'b0;
        wait_cycles(6);
        rxd = 1'b1;
        wait_cycles(200);
        bus_read(12'h000, r);
        checks++;
        if (r !== 32'h1) begin failures++; $display("FAIL rx_glitch_status got=%h expected=1", r); end
    endtask
`else
    task automatic test_rx_disabled();
        logic [31:0] r;
        bus_write(12'h00C, 32'd16);
        send_rx(8'h3C, 16, 1'b1);
        send_rx(8'h55, 16, 1'b0);
        bus_read(12'h000, r);
        checks++;
        if (r !== 32'h1) begin failures++; $display("FAIL rx_off_status got=%h expected=1", r); end
        bus_read(12'h008, r);
        checks++;
        if (r !== 32'h0) begin failures++; $display("FAIL rx_off_data got=%h expected=0", r); end
    endtask
`endif

    initial begin
        test_reset();
        test_div();
        test_tx_basic();
        test_tx_random();
        test_fifo_full();
        test_reset_mid_frame();
`ifdef RISCV_UART_RX_EN
        test_rx_basic();
        test_rx_random();
        test_rx_overrun();
        test_rx_frame_err();
`else
        test_rx_disabled();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
